// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline controller.
//   state_t  : controller state encoding (RUN=0, MD_WAIT=1)
//   REG_ZERO : architectural zero register number; never a real hazard source
package pipeline_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare (purely combinational).
//   i_mem_read_EX, i_rt_EX : load in EX and its destination register
//   i_rs_ID, i_rt_ID       : source registers of the instruction in ID
//   i_uses_rt_ID           : ID instruction actually reads rt
//   o_hazard               : ID must wait one cycle for the load result
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic       i_mem_read_EX,
  input  logic [4:0] i_rt_EX,
  input  logic [4:0] i_rs_ID,
  input  logic [4:0] i_rt_ID,
  input  logic       i_uses_rt_ID,
  output logic       o_hazard
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (i_rt_EX == i_rs_ID);
  // rt only counts when the ID instruction really reads it (e.g. not an I-type dest)
  assign w_rt_match = i_uses_rt_ID && (i_rt_EX == i_rt_ID);
  // loads into r0 are discarded, so they never create a dependency
  assign o_hazard   = i_mem_read_EX && (i_rt_EX != REG_ZERO) && (w_rs_match || w_rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller.
//   clk, reset (sync, active-high)
//   rs_ID, rt_ID, uses_rt_ID       : ID-stage operand info
//   mem_read_EX, rt_EX             : load in EX
//   muldiv_ID                      : ID instruction is a multi-cycle mul/div
//   branch_taken_EX                : redirect resolved in EX
//   pc_write, if_id_write, id_ex_write : stage-register enables
//   if_id_flush, id_ex_bubble      : insert NOPs
//   muldiv_busy                    : EX held by a mul/div
//   stall_count                    : saturating count of cycles with pc_write=0
// MULDIV_CYCLES is the total EX occupancy of a mul/div (2..255).
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_ID,
  input  logic [4:0]  rt_ID,
  input  logic        uses_rt_ID,
  input  logic        mem_read_EX,
  input  logic [4:0]  rt_EX,
  input  logic        muldiv_ID,
  input  logic        branch_taken_EX,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        muldiv_busy,
  output logic [15:0] stall_count
);

  // first cycle in EX happens in RUN, so MD_WAIT covers the remaining cycles
  localparam logic [7:0] MD_INIT = 8'(MULDIV_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_md_cnt;
  logic [7:0]  w_md_cnt_nxt;
  logic [15:0] r_stall_cnt;
  logic        w_hazard;

  hazard_detect u_hazard (
    .i_mem_read_EX (mem_read_EX),
    .i_rt_EX       (rt_EX),
    .i_rs_ID       (rs_ID),
    .i_rt_ID       (rt_ID),
    .i_uses_rt_ID  (uses_rt_ID),
    .o_hazard      (w_hazard)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_md_cnt    <= 8'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
      if (!pc_write && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    muldiv_busy  = 1'b0;

    if (reset) begin
      // hold everything and keep NOPs flowing until reset releases
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      unique case (r_state)
        RUN: begin
          if (branch_taken_EX) begin
            // redirect wins: wrong-path IF/ID and ID/EX contents are squashed
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (w_hazard) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (muldiv_ID) begin
            w_state_nxt  = MD_WAIT;
            w_md_cnt_nxt = MD_INIT;
          end
        end
        MD_WAIT: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          muldiv_busy  = 1'b1;
          w_md_cnt_nxt = r_md_cnt - 8'd1;
          if (r_md_cnt == 8'd1)
            w_state_nxt = RUN;
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (MULDIV_CYCLES=4).
// Output vector order: {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_bubble, muldiv_busy}
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_ID, rt_ID, rt_EX;
  logic        uses_rt_ID, mem_read_EX, muldiv_ID, branch_taken_EX;
  logic        pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_bubble, muldiv_busy;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall = 0;

  localparam logic [5:0] O_RUN   = 6'b111000;
  localparam logic [5:0] O_LU    = 6'b011010 & 6'b001010 | 6'b001010; // id_ex_write + bubble only
  localparam logic [5:0] O_BR    = 6'b111110;
  localparam logic [5:0] O_MD    = 6'b000001;
  localparam logic [5:0] O_RST   = 6'b000110;

  pipeline_ctrl #(.MULDIV_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rt_ID(uses_rt_ID),
    .mem_read_EX(mem_read_EX), .rt_EX(rt_EX),
    .muldiv_ID(muldiv_ID), .branch_taken_EX(branch_taken_EX),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .muldiv_busy(muldiv_busy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  wire [5:0] outs = {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_bubble, muldiv_busy};

  // advance one edge; inputs change 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs_ID = 5'd1; rt_ID = 5'd2; rt_EX = 5'd3;
    uses_rt_ID = 1'b0; mem_read_EX = 1'b0; muldiv_ID = 1'b0; branch_taken_EX = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    n_checks++;
    if (outs !== O_RST) begin
      n_fail++; $display("FAIL reset_outs got=%b exp=%b", outs, O_RST);
    end
    tick(); tick();
    n_checks++;
    if (stall_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_stall got=%0d exp=0", stall_count);
    end
    reset = 1'b0;
    exp_stall = 0;
    #1;
    n_checks++;
    if (outs !== O_RUN) begin
      n_fail++; $display("FAIL post_reset_run got=%b exp=%b", outs, O_RUN);
    end
    tick();
  endtask

  task automatic test_load_use();
    mem_read_EX = 1'b1; rt_EX = 5'd8; rs_ID = 5'd8;
    #1;
    n_checks++;
    if (outs !== 6'b001010) begin
      n_fail++; $display("FAIL load_use_outs got=%b exp=%b", outs, 6'b001010);
    end
    tick(); exp_stall++;
    idle_inputs();
    #1;
    n_checks++;
    if (outs !== O_RUN) begin
      n_fail++; $display("FAIL load_use_release got=%b exp=%b", outs, O_RUN);
    end
    n_checks++;
    if (stall_count !== 16'(exp_stall)) begin
      n_fail++; $display("FAIL load_use_count got=%0d exp=%0d", stall_count, exp_stall);
    end
    // rt path with uses_rt_ID=1 is a real hazard
    mem_read_EX = 1'b1; rt_EX = 5'd9; rt_ID = 5'd9; rs_ID = 5'd3; uses_rt_ID = 1'b1;
    #1;
    n_checks++;
    if (outs !== 6'b001010) begin
      n_fail++; $display("FAIL load_use_rt got=%b exp=%b", outs, 6'b001010);
    end
    tick(); exp_stall++;
    idle_inputs();
  endtask

  task automatic test_no_false_stall();
    mem_read_EX = 1'b1; rt_EX = 5'd0; rs_ID = 5'd0; rt_ID = 5'd0; uses_rt_ID = 1'b1;
    #1;
    n_checks++;
    if (outs !== O_RUN) begin
      n_fail++; $display("FAIL no_stall_r0 got=%b exp=%b", outs, O_RUN);
    end
    tick();
    mem_read_EX = 1'b1; rt_EX = 5'd9; rt_ID = 5'd9; rs_ID = 5'd3; uses_rt_ID = 1'b0;
    #1;
    n_checks++;
    if (outs !== O_RUN) begin
      n_fail++; $display("FAIL no_stall_rt_unused got=%b exp=%b", outs, O_RUN);
    end
    tick();
    mem_read_EX = 1'b0; rt_EX = 5'd8; rs_ID = 5'd8;
    #1;
    n_checks++;
    if (outs !== O_RUN) begin
      n_fail++; $display("FAIL no_stall_not_load got=%b exp=%b", outs, O_RUN);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (stall_count !== 16'(exp_stall)) begin
      n_fail++; $display("FAIL no_stall_count got=%0d exp=%0d", stall_count, exp_stall);
    end
  endtask

  task automatic test_branch_priority();
    branch_taken_EX = 1'b1; mem_read_EX = 1'b1; rt_EX = 5'd8; rs_ID = 5'd8; muldiv_ID = 1'b1;
    #1;
    n_checks++;
    if (outs !== O_BR) begin
      n_fail++; $display("FAIL branch_outs got=%b exp=%b", outs, O_BR);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (outs !== O_RUN) begin
      n_fail++; $display("FAIL branch_stays_run got=%b exp=%b", outs, O_RUN);
    end
    n_checks++;
    if (stall_count !== 16'(exp_stall)) begin
      n_fail++; $display("FAIL branch_count got=%0d exp=%0d", stall_count, exp_stall);
    end
  endtask

  task automatic test_muldiv();
    muldiv_ID = 1'b1;
    #1;
    n_checks++;
    if (outs !== O_RUN) begin
      n_fail++; $display("FAIL md_issue got=%b exp=%b", outs, O_RUN);
    end
    tick();
    muldiv_ID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      // hazard/branch/muldiv must be ignored while waiting
      if (i == 1) begin
        branch_taken_EX = 1'b1; muldiv_ID = 1'b1; mem_read_EX = 1'b1; rt_EX = 5'd4; rs_ID = 5'd4;
      end else idle_inputs();
      #1;
      n_checks++;
      if (outs !== O_MD) begin
        n_fail++; $display("FAIL md_wait_%0d got=%b exp=%b", i, outs, O_MD);
      end
      tick(); exp_stall++;
    end
    idle_inputs();
    #1;
    n_checks++;
    if (outs !== O_RUN) begin
      n_fail++; $display("FAIL md_done got=%b exp=%b", outs, O_RUN);
    end
    n_checks++;
    if (stall_count !== 16'(exp_stall)) begin
      n_fail++; $display("FAIL md_count got=%0d exp=%0d", stall_count, exp_stall);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    muldiv_ID = 1'b1;
    tick();              // enters MD_WAIT, md_cnt=3
    muldiv_ID = 1'b0;
    tick();              // md_cnt=2
    n_checks++;
    if (dut.r_md_cnt !== 8'd2) begin
      n_fail++; $display("FAIL mid_wait_cnt got=%0d exp=2", dut.r_md_cnt);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (outs !== O_RST) begin
      n_fail++; $display("FAIL mid_wait_rst_outs got=%b exp=%b", outs, O_RST);
    end
    tick();
    reset = 1'b0;
    exp_stall = 0;
    #1;
    n_checks++;
    if (outs !== O_RUN) begin
      n_fail++; $display("FAIL mid_wait_aborted got=%b exp=%b", outs, O_RUN);
    end
    n_checks++;
    if ({dut.r_md_cnt, stall_count} !== 24'd0) begin
      n_fail++; $display("FAIL mid_wait_clear got md_cnt=%0d stall=%0d exp 0/0", dut.r_md_cnt, stall_count);
    end
    tick();
  endtask

  task automatic test_saturation();
    mem_read_EX = 1'b1; rt_EX = 5'd8; rs_ID = 5'd8;
    for (int i = 0; i < 65540; i++) tick();
    n_checks++;
    if (stall_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_hold got=%h exp=ffff", stall_count);
    end
    n_checks++;
    if (pc_write !== 1'b0) begin
      n_fail++; $display("FAIL sat_still_stalling got=%b exp=0", pc_write);
    end
    tick();
    n_checks++;
    if (stall_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_no_wrap got=%h exp=ffff", stall_count);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #1;
    test_reset();
    test_load_use();
    test_no_false_stall();
    test_branch_priority();
    test_muldiv();
    test_reset_mid_wait();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MULDIV_CYCLES, default 32: EX-stage occupancy of a mul/div instruction in cycles; legal range 2..255.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports rs_ID, rt_ID  in  5 each  source register numbers of the instruction in ID.
REQ-005 SHALL have port uses_rt_ID  in  1  ID instruction reads rt.
REQ-006 SHALL have ports mem_read_EX  in  1, rt_EX  in  5  load in EX and its destination register.
REQ-007 SHALL have port muldiv_ID  in  1  ID instruction is mul/div.
REQ-008 SHALL have port branch_taken_EX  in  1  branch or jump resolved taken in EX.
REQ-009 SHALL have ports pc_write, if_id_write, id_ex_write  out  1 each  stage-register enables.
REQ-010 SHALL have ports if_id_flush, id_ex_bubble  out  1 each  load a NOP into IF/ID or ID/EX.
REQ-011 SHALL have ports muldiv_busy  out  1; stall_count  out  16  saturating count of stall cycles.

Function
REQ-012 SHALL hold a registered state in {RUN, MD_WAIT} and an 8-bit down-counter md_cnt.
REQ-013 SHALL detect a load-use hazard when mem_read_EX=1, rt_EX!=0, and (rt_EX==rs_ID or (uses_rt_ID=1 and rt_EX==rt_ID)).
REQ-014 In RUN with no hazard and no branch, SHALL drive pc_write=if_id_write=id_ex_write=1, flush=bubble=0, same cycle (combinational from state and inputs).
REQ-015 In RUN on load-use hazard without branch, SHALL drive pc_write=0, if_id_write=0, id_ex_write=1, id_ex_bubble=1 for exactly that cycle; no state change.
REQ-016 In RUN with branch_taken_EX=1, SHALL drive if_id_flush=1, id_ex_bubble=1, pc_write=if_id_write=id_ex_write=1; overrides load-use and muldiv_ID.
REQ-017 In RUN with muldiv_ID=1, no hazard and no branch, SHALL let the instruction enter EX and on the next edge go to MD_WAIT with md_cnt=MULDIV_CYCLES-1.
REQ-018 In MD_WAIT, SHALL drive pc_write=if_id_write=id_ex_write=0, flush=bubble=0, muldiv_busy=1, and decrement md_cnt each cycle.
REQ-019 In MD_WAIT, SHALL return to RUN on the edge where md_cnt==1, so EX is held MULDIV_CYCLES-1 extra cycles; total EX occupancy is MULDIV_CYCLES.
REQ-020 SHALL ignore branch_taken_EX, muldiv_ID and hazard inputs while in MD_WAIT.
REQ-021 SHALL increment stall_count each cycle pc_write=0 with reset=0, saturating at 0xFFFF.

Reset
REQ-022 While reset=1, outputs SHALL be pc_write=if_id_write=id_ex_write=0, if_id_flush=id_ex_bubble=1, muldiv_busy=0.
REQ-023 On an edge with reset=1, SHALL set state=RUN, md_cnt=0, stall_count=0; reset in MD_WAIT SHALL abort the wait.
REQ-024 In the first cycle after reset deasserts, SHALL behave per REQ-014..017.

Structure
REQ-025 SHALL take the state encoding (RUN=0, MD_WAIT=1) and REG_ZERO=5'd0 from shared package pipeline_pkg.
REQ-026 SHALL place the REQ-013 compare in one combinational sub-module hazard_detect; everything else stays in pipeline_ctrl.

Verification
REQ-027 Load-use: mem_read_EX=1, rt_EX=8, rs_ID=8 -> one cycle pc_write=0, id_ex_bubble=1; next cycle all enables 1; stall_count=1.
REQ-028 No false stall: rt_EX=0=rs_ID, or rt_EX=9=rt_ID with uses_rt_ID=0 -> no stall.
REQ-029 Branch priority: branch_taken_EX=1 with load-use hazard and muldiv_ID=1 -> if_id_flush=1, id_ex_bubble=1, pc_write=1, state stays RUN.
REQ-030 Mul/div with MULDIV_CYCLES=4: muldiv_ID=1 -> 3 cycles muldiv_busy=1, enables 0, then RUN; stall_count=3.
REQ-031 Reset mid-wait: reset=1 at md_cnt=2 -> next cycle RUN, md_cnt=0, stall_count=0, muldiv_busy=0.
REQ-032 Saturation: stall 65540 cycles -> stall_count holds 0xFFFF.
